tl_ul_sram_slave: RTL and testbench

TileLink-UL responder: accepts A-channel requests (Get, PutFullData, PutPartialData), performs the access on a single-port synchronous SRAM port, and returns in-order D-channel responses (AccessAckData / AccessAck). It is the slave end facing a TL-UL master such as a core LSU or crossbar port. Widths and opcode encodings come from `tilelink_pkg`. A response FIFO decouples D backpressure from the memory pipeline.

---
 rtl/tl_ul_sram_slave.sv | 178 +++++++++++++++++
 tb/tb_tl_ul_sram_slave.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_sram_slave.sv
// TileLink-UL responder for a single-port synchronous SRAM: decodes A-channel
// Get/Put requests and returns in-order D-channel acks through a response FIFO.
package tilelink_pkg;
  localparam int TL_AW   = 32;
  localparam int TL_DW   = 32;
  localparam int TL_DBW  = TL_DW / 8;
  localparam int TL_SZW  = 2;
  localparam int TL_SRCW = 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    ArithmeticData = 3'h2,
    LogicalData    = 3'h3,
    Get            = 3'h4,
    Intent         = 3'h5
  } tl_a_opcode_e;
endpackage

module tl_ul_sram_slave
  import tilelink_pkg::*;
#(
  parameter int MEM_AW    = 10,
  parameter int RSP_DEPTH = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 a_valid,
  input  tl_a_opcode_e         a_opcode,
  input  logic [2:0]           a_param,
  input  logic [TL_SZW-1:0]    a_size,
  input  logic [TL_SRCW-1:0]   a_source,
  input  logic [TL_AW-1:0]     a_address,
  input  logic [TL_DBW-1:0]    a_mask,
  input  logic [TL_DW-1:0]     a_data,
  input  logic                 a_corrupt,
  output logic                 a_ready,
  output logic                 d_valid,
  output logic [2:0]           d_opcode,
  output logic [1:0]           d_param,
  output logic [TL_SZW-1:0]    d_size,
  output logic [TL_SRCW-1:0]   d_source,
  output logic                 d_sink,
  output logic [TL_DW-1:0]     d_data,
  output logic                 d_denied,
  output logic                 d_corrupt,
  input  logic                 d_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic [TL_DW-1:0]     mem_wdata,
  output logic [TL_DBW-1:0]    mem_be,
  input  logic [TL_DW-1:0]     mem_rdata
);

  localparam int OFF = $clog2(TL_DBW);
  localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW  = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic                get;
    logic [TL_SZW-1:0]   size;
    logic [TL_SRCW-1:0]  source;
    logic                err;
    logic [TL_DW-1:0]    data;
  } rsp_t;

  // Both channels use plain valid/ready: a transfer happens on the rising edge
  // where valid && ready; the sender holds its payload stable until then.

  logic               is_get, is_put, err, accept;
  logic               misalign, high_err, mask_err;
  logic [OFF-1:0]     byte_off;
  logic [TL_DBW-1:0]  lane_mask;

  assign byte_off = a_address[OFF-1:0];

  always_comb begin
    is_get    = (a_opcode == Get);
    is_put    = (a_opcode == PutFullData) || (a_opcode == PutPartialData);
    lane_mask = '0;
    for (int i = 0; i < TL_DBW; i++) begin
      lane_mask[i] = (i >= int'(byte_off)) &&
                     (i < int'(byte_off) + (1 << int'(a_size)));
    end
    misalign = (int'(byte_off) & ((1 << int'(a_size)) - 1)) != 0;
    high_err = (a_address >> (OFF + MEM_AW)) != '0;
    mask_err = (a_opcode == PutFullData) && (a_mask != lane_mask);
    err      = !(is_get || is_put) || (a_param != 3'd0) ||
               (int'(a_size) > OFF) || misalign || high_err || mask_err ||
               (is_put && a_corrupt);
  end

  // Errored requests still take a pipeline slot but never touch the SRAM.
  assign accept    = a_valid && a_ready;
  assign mem_req   = accept && !err;
  assign mem_we    = mem_req && is_put;
  assign mem_be    = is_put ? a_mask : '1;
  assign mem_addr  = a_address[OFF+MEM_AW-1:OFF];
  assign mem_wdata = a_data;

  logic               inf_valid, inf_get, inf_err;
  logic [TL_SZW-1:0]  inf_size;
  logic [TL_SRCW-1:0] inf_source;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inf_valid  <= 1'b0;
      inf_get    <= 1'b0;
      inf_err    <= 1'b0;
      inf_size   <= '0;
      inf_source <= '0;
    end else begin
      inf_valid <= accept;
      if (accept) begin
        inf_get    <= is_get;
        inf_err    <= err;
        inf_size   <= a_size;
        inf_source <= a_source;
      end
    end
  end

  rsp_t            fifo [RSP_DEPTH];
  rsp_t            push_entry, head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            push, pop;

  assign push = inf_valid;
  assign pop  = d_valid && d_ready;

  always_comb begin
    push_entry        = '0;
    push_entry.get    = inf_get;
    push_entry.size   = inf_size;
    push_entry.source = inf_source;
    push_entry.err    = inf_err;
    push_entry.data   = (inf_get && !inf_err) ? mem_rdata : '0;
  end

  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The inflight slot is reserved up front so a push can never overflow.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inf_valid};
  assign a_ready   = !reset && (occupancy < (CW+1)'(RSP_DEPTH));

  assign head      = fifo[rd_ptr];
  assign d_valid   = (count != '0);
  assign d_opcode  = {2'b00, d_valid && head.get};
  assign d_param   = 2'b00;
  assign d_sink    = 1'b0;
  assign d_size    = d_valid ? head.size : '0;
  assign d_source  = d_valid ? head.source : '0;
  assign d_data    = d_valid ? head.data : '0;
  assign d_denied  = d_valid && head.err;
  assign d_corrupt = d_valid && head.err && head.get;

endmodule

// File: tb/tb_tl_ul_sram_slave.sv
// Directed bench for tl_ul_sram_slave: SRAM model, response monitor and
// per-scenario tasks comparing observed D responses against hand-built values.
module tb_tl_ul_sram_slave;
  import tilelink_pkg::*;

  logic         clock, reset;
  logic         a_valid, a_ready, a_corrupt;
  tl_a_opcode_e a_opcode;
  logic [2:0]   a_param;
  logic [1:0]   a_size;
  logic [7:0]   a_source;
  logic [31:0]  a_address, a_data;
  logic [3:0]   a_mask;
  logic         d_valid, d_ready, d_sink, d_denied, d_corrupt;
  logic [2:0]   d_opcode;
  logic [1:0]   d_param, d_size;
  logic [7:0]   d_source;
  logic [31:0]  d_data;
  logic         mem_req, mem_we;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_wdata, mem_rdata;
  logic [3:0]   mem_be;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [46:0] exp_q[$];
  int          exp_cyc[$];
  logic [46:0] got_q[$];
  int          got_cyc[$];
  logic [31:0] sram [1024];

  tl_ul_sram_slave #(.MEM_AW(10), .RSP_DEPTH(3)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .a_corrupt(a_corrupt), .a_ready(a_ready),
    .d_valid(d_valid), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_source(d_source), .d_sink(d_sink), .d_data(d_data), .d_denied(d_denied),
    .d_corrupt(d_corrupt), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  // synchronous SRAM with byte enables, read data valid the next cycle
  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = '0;
    mem_rdata = '0;
  end

  always @(posedge clock) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  // D-channel monitor, sampled mid-low-phase
  always @(negedge clock) begin
    #2;
    if (!reset && d_valid && d_ready) begin
      got_q.push_back({d_opcode, d_size, d_source, d_data, d_denied, d_corrupt});
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [46:0] mk(input logic [2:0] op, input logic [1:0] sz,
                                     input logic [7:0] src, input logic [31:0] dat,
                                     input logic den, input logic cor);
    return {op, sz, src, dat, den, cor};
  endfunction

  // driver tasks
  task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] src,
                      input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] data, output int acc, output logic req,
                      output logic we, output int waits);
    a_opcode  = tl_a_opcode_e'(op);
    a_param   = 3'd0;
    a_size    = sz;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    a_corrupt = 1'b0;
    a_valid   = 1'b1;
    waits     = 0;
    #1;
    while (!a_ready && waits < 50) begin
      @(negedge clock);
      #1;
      waits++;
    end
    req = mem_req;
    we  = mem_we;
    acc = cyc;
    @(negedge clock);
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    int k = 0;
    while (got_q.size() < n && k < 100) begin
      @(negedge clock);
      #3;
      k++;
    end
    ok = (got_q.size() >= n);
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    #1;
    total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL reset_d_valid got=%b exp=0", d_valid); end
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    total++; if (d_data !== 32'h0) begin bad++; $display("FAIL reset_d_data got=%h exp=0", d_data); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL post_reset_a_ready got=%b exp=1", a_ready); end
    @(negedge clock);
  endtask

  task automatic test_put_get();
    int acc, w; logic req, we; bit ok;
    logic [46:0] g, e; int gc, ec;
    d_ready = 1'b1;
    send(3'd0, 2'd2, 8'h01, 32'h10, 4'hF, 32'hDEADBEEF, acc, req, we, w);
    total++; if ({req, we} !== 2'b11) begin bad++; $display("FAIL put_mem_req_we got=%b exp=11", {req, we}); end
    exp_q.push_back(mk(3'd0, 2'd2, 8'h01, 32'h0, 1'b0, 1'b0)); exp_cyc.push_back(acc + 2);
    send(3'd4, 2'd2, 8'h02, 32'h10, 4'hF, 32'h0, acc, req, we, w);
    total++; if ({req, we} !== 2'b10) begin bad++; $display("FAIL get_mem_req_we got=%b exp=10", {req, we}); end
    exp_q.push_back(mk(3'd1, 2'd2, 8'h02, 32'hDEADBEEF, 1'b0, 1'b0)); exp_cyc.push_back(acc + 2);
    a_valid = 1'b0;
    wait_rsp(2, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL put_get_timeout got=%0d exp=2 responses", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        g = got_q.pop_front(); gc = got_cyc.pop_front();
        e = exp_q.pop_front(); ec = exp_cyc.pop_front();
        total++; if (g !== e) begin bad++; $display("FAIL put_get_rsp%0d got=%h exp=%h", i, g, e); end
        total++; if (gc !== ec) begin bad++; $display("FAIL put_get_latency%0d got=%0d exp=%0d", i, gc, ec); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc, w, first; logic req, we; bit ok;
    logic [46:0] g, e; int gc, ec;
    d_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(3'd0, 2'd2, 8'(i), 32'h100 + 32'(4*i), 4'hF, 32'hC0DE0000 + 32'(i), acc, req, we, w);
      exp_q.push_back(mk(3'd0, 2'd2, 8'(i), 32'h0, 1'b0, 1'b0));
    end
    a_valid = 1'b0;
    wait_rsp(16, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL b2b_put_timeout got=%0d exp=16 responses", got_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        g = got_q.pop_front(); gc = got_cyc.pop_front(); e = exp_q.pop_front();
        total++; if (g !== e) begin bad++; $display("FAIL b2b_put_rsp%0d got=%h exp=%h", i, g, e); end
      end
    end
    @(negedge clock);
    first = 0;
    for (int i = 0; i < 16; i++) begin
      send(3'd4, 2'd2, 8'(i), 32'h100 + 32'(4*i), 4'hF, 32'h0, acc, req, we, w);
      if (i == 0) first = acc;
      total++; if (w !== 0) begin bad++; $display("FAIL b2b_a_ready_low%0d got=%0d exp=0 waits", i, w); end
      total++; if (acc !== first + i) begin bad++; $display("FAIL b2b_accept_cycle%0d got=%0d exp=%0d", i, acc, first + i); end
      exp_q.push_back(mk(3'd1, 2'd2, 8'(i), 32'hC0DE0000 + 32'(i), 1'b0, 1'b0));
      exp_cyc.push_back(first + i + 2);
    end
    a_valid = 1'b0;
    wait_rsp(16, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL b2b_get_timeout got=%0d exp=16 responses", got_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        g = got_q.pop_front(); gc = got_cyc.pop_front();
        e = exp_q.pop_front(); ec = exp_cyc.pop_front();
        total++; if (g !== e) begin bad++; $display("FAIL b2b_get_rsp%0d got=%h exp=%h", i, g, e); end
        total++; if (gc !== ec) begin bad++; $display("FAIL b2b_get_cycle%0d got=%0d exp=%0d", i, gc, ec); end
      end
    end
  endtask

  task automatic test_stall();
    int accepted; bit ok;
    logic [46:0] g, e; int gc;
    @(negedge clock);
    d_ready  = 1'b0;
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      a_opcode  = Get;  a_param = 3'd0; a_size = 2'd2; a_mask = 4'hF;
      a_data    = '0;   a_corrupt = 1'b0;
      a_source  = 8'h20 + 8'(accepted);
      a_address = 32'h100 + 32'(4*accepted);
      a_valid   = 1'b1;
      #1;
      if (a_ready) begin
        exp_q.push_back(mk(3'd1, 2'd2, 8'h20 + 8'(accepted), 32'hC0DE0000 + 32'(accepted), 1'b0, 1'b0));
        accepted++;
      end
      @(negedge clock);
    end
    a_valid = 1'b0;
    #1;
    total++; if (accepted !== 3) begin bad++; $display("FAIL stall_accepts got=%0d exp=3", accepted); end
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL stall_a_ready got=%b exp=0", a_ready); end
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({d_valid, d_opcode, d_source, d_data} !== {1'b1, 3'd1, 8'h20, 32'hC0DE0000}) begin
        bad++; $display("FAIL stall_head_hold%0d got=%b/%0d/%h/%h exp=1/1/20/c0de0000",
                        c, d_valid, d_opcode, d_source, d_data);
      end
      @(negedge clock);
      #1;
    end
    @(negedge clock);
    d_ready = 1'b1;
    #1;
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL stall_ready_same_cycle got=%b exp=0", a_ready); end
    @(negedge clock);
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_after_pop got=%b exp=1", a_ready); end
    wait_rsp(3, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL stall_timeout got=%0d exp=3 responses", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        g = got_q.pop_front(); gc = got_cyc.pop_front(); e = exp_q.pop_front();
        total++; if (g !== e) begin bad++; $display("FAIL stall_rsp%0d got=%h exp=%h", i, g, e); end
      end
    end
  endtask

  task automatic test_partial();
    int acc, w; logic req, we; bit ok;
    logic [46:0] g, e; int gc, ec;
    @(negedge clock);
    d_ready = 1'b1;
    send(3'd0, 2'd2, 8'h30, 32'h20, 4'hF, 32'h11223344, acc, req, we, w);
    exp_q.push_back(mk(3'd0, 2'd2, 8'h30, 32'h0, 1'b0, 1'b0)); exp_cyc.push_back(acc + 2);
    send(3'd1, 2'd2, 8'h31, 32'h20, 4'b0101, 32'hAABBCCDD, acc, req, we, w);
    total++; if ({req, we} !== 2'b11) begin bad++; $display("FAIL partial_mem_req_we got=%b exp=11", {req, we}); end
    exp_q.push_back(mk(3'd0, 2'd2, 8'h31, 32'h0, 1'b0, 1'b0)); exp_cyc.push_back(acc + 2);
    send(3'd4, 2'd2, 8'h32, 32'h20, 4'hF, 32'h0, acc, req, we, w);
    exp_q.push_back(mk(3'd1, 2'd2, 8'h32, 32'h11BB33DD, 1'b0, 1'b0)); exp_cyc.push_back(acc + 2);
    a_valid = 1'b0;
    wait_rsp(3, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL partial_timeout got=%0d exp=3 responses", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        g = got_q.pop_front(); gc = got_cyc.pop_front();
        e = exp_q.pop_front(); ec = exp_cyc.pop_front();
        total++; if (g !== e) begin bad++; $display("FAIL partial_rsp%0d got=%h exp=%h", i, g, e); end
        total++; if (gc !== ec) begin bad++; $display("FAIL partial_latency%0d got=%0d exp=%0d", i, gc, ec); end
      end
    end
  endtask

  task automatic test_errors();
    int acc, w; logic req, we; bit ok;
    logic [46:0] g, e; int gc;
    @(negedge clock);
    d_ready = 1'b1;
    send(3'd4, 2'd2, 8'h40, 32'h2, 4'hF, 32'h0, acc, req, we, w);
    total++; if (req !== 1'b0) begin bad++; $display("FAIL err_misalign_mem_req got=%b exp=0", req); end
    exp_q.push_back(mk(3'd1, 2'd2, 8'h40, 32'h0, 1'b1, 1'b1));
    send(3'd0, 2'd2, 8'h41, 32'h24, 4'h3, 32'h55555555, acc, req, we, w);
    total++; if (req !== 1'b0) begin bad++; $display("FAIL err_mask_mem_req got=%b exp=0", req); end
    exp_q.push_back(mk(3'd0, 2'd2, 8'h41, 32'h0, 1'b1, 1'b0));
    send(3'd0, 2'd2, 8'h42, 32'h1010, 4'hF, 32'h66666666, acc, req, we, w);
    total++; if (req !== 1'b0) begin bad++; $display("FAIL err_range_mem_req got=%b exp=0", req); end
    exp_q.push_back(mk(3'd0, 2'd2, 8'h42, 32'h0, 1'b1, 1'b0));
    send(3'd4, 2'd2, 8'h43, 32'h10, 4'hF, 32'h0, acc, req, we, w);
    exp_q.push_back(mk(3'd1, 2'd2, 8'h43, 32'hDEADBEEF, 1'b0, 1'b0));
    send(3'd4, 2'd2, 8'h44, 32'h24, 4'hF, 32'h0, acc, req, we, w);
    exp_q.push_back(mk(3'd1, 2'd2, 8'h44, 32'h0, 1'b0, 1'b0));
    a_valid = 1'b0;
    wait_rsp(5, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL err_timeout got=%0d exp=5 responses", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        g = got_q.pop_front(); gc = got_cyc.pop_front(); e = exp_q.pop_front();
        total++; if (g !== e) begin bad++; $display("FAIL err_rsp%0d got=%h exp=%h", i, g, e); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    int acc, w; logic req, we; bit ok;
    logic [46:0] g, e; int gc, ec;
    @(negedge clock);
    d_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(3'd4, 2'd2, 8'h50 + 8'(i), 32'h10, 4'hF, 32'h0, acc, req, we, w);
    a_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL midreset_d_valid got=%b exp=0", d_valid); end
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL midreset_a_ready got=%b exp=0", a_ready); end
    total++; if ({d_data, d_source} !== 40'h0) begin bad++; $display("FAIL midreset_d_fields got=%h exp=0", {d_data, d_source}); end
    @(negedge clock);
    @(negedge clock);
    reset   = 1'b0;
    d_ready = 1'b1;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL midreset_first_accept got=%b exp=1", a_ready); end
    for (int c = 0; c < 6; c++) @(negedge clock);
    #3;
    total++; if (got_q.size() !== 0) begin bad++; $display("FAIL midreset_stale got=%0d exp=0 responses", got_q.size()); end
    @(negedge clock);
    send(3'd4, 2'd2, 8'h77, 32'h10, 4'hF, 32'h0, acc, req, we, w);
    exp_q.push_back(mk(3'd1, 2'd2, 8'h77, 32'hDEADBEEF, 1'b0, 1'b0)); exp_cyc.push_back(acc + 2);
    a_valid = 1'b0;
    wait_rsp(1, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL midreset_get_timeout got=%0d exp=1 responses", got_q.size());
    end else begin
      g = got_q.pop_front(); gc = got_cyc.pop_front();
      e = exp_q.pop_front(); ec = exp_cyc.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL midreset_get_rsp got=%h exp=%h", g, e); end
      total++; if (gc !== ec) begin bad++; $display("FAIL midreset_get_latency got=%0d exp=%0d", gc, ec); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    a_valid   = 1'b0;
    a_opcode  = Get;
    a_param   = '0;
    a_size    = '0;
    a_source  = '0;
    a_address = '0;
    a_mask    = '0;
    a_data    = '0;
    a_corrupt = 1'b0;
    d_ready   = 1'b0;
    test_reset();
    test_put_get();
    test_back_to_back();
    test_stall();
    test_partial();
    test_errors();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
